// File: rtl/psum_accumulator.sv
// Partial-sum accumulator: sums CSA result terms into groups with saturation
// and hands each group total downstream through a valid/ready output.
module psum_accumulator #(
  parameter int unsigned IN_W      = 6,
  parameter int unsigned ACC_W     = 10,
  parameter int unsigned MAX_TERMS = 8,
  parameter int unsigned CNT_W     = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  in_data,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_data,
  output logic [CNT_W-1:0] out_count,
  output logic             out_ovf
);

  localparam int unsigned SUM_W = ACC_W + 1;

  typedef enum logic {
    ST_ACC  = 1'b0,
    ST_DONE = 1'b1
  } state_t;

  state_t           state;
  state_t           state_next;

  logic [ACC_W-1:0] acc;
  logic [CNT_W-1:0] cnt;
  logic             ovf;

  logic             accept;
  logic             close;
  logic [SUM_W-1:0] sum_ext;
  logic [ACC_W-1:0] acc_new;
  logic [CNT_W-1:0] cnt_new;
  logic             ovf_new;

  // Running group registers are cleared whenever a group closes, so acc is
  // already zero in DONE and a zero-bubble reload needs no special path.
  assign accept  = in_valid && in_ready;
  assign sum_ext = {1'b0, acc} + SUM_W'(in_data);
  assign acc_new = sum_ext[ACC_W] ? {ACC_W{1'b1}} : sum_ext[ACC_W-1:0];
  assign ovf_new = ovf | sum_ext[ACC_W];
  assign cnt_new = cnt + CNT_W'(1);
  assign close   = in_last || (cnt_new == CNT_W'(MAX_TERMS));

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_ACC;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    unique case (state)
      ST_ACC: begin
        if (accept && close) begin
          state_next = ST_DONE;
        end
      end
      ST_DONE: begin
        if (out_ready) begin
          state_next = (accept && close) ? ST_DONE : ST_ACC;
        end
      end
      default: state_next = ST_ACC;
    endcase
  end

  // Handshake outputs decoded from the state register
  always_comb begin
    out_valid = 1'b0;
    in_ready  = 1'b1;
    out_valid = (state == ST_DONE);
    in_ready  = !out_valid || out_ready;
  end

  // Accumulator and result registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc       <= '0;
      cnt       <= '0;
      ovf       <= 1'b0;
      out_data  <= '0;
      out_count <= '0;
      out_ovf   <= 1'b0;
    end else if (accept) begin
      if (close) begin
        out_data  <= acc_new;
        out_count <= cnt_new;
        out_ovf   <= ovf_new;
        acc       <= '0;
        cnt       <= '0;
        ovf       <= 1'b0;
      end else begin
        acc <= acc_new;
        cnt <= cnt_new;
        ovf <= ovf_new;
      end
    end
  end

endmodule

// File: tb/tb_psum_accumulator.sv
// Scoreboard bench for psum_accumulator: three configurations share one
// stimulus stream; a group-level reference model predicts every result.
module tb_psum_accumulator;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic [5:0] in_data;
  logic       in_last;
  logic       out_ready;

  // dut0: ACC_W=10, MAX_TERMS=8; dut1: ACC_W=8, MAX_TERMS=8; dut2: ACC_W=10, MAX_TERMS=1
  logic       ir0, ir1, ir2;
  logic       ov0, ov1, ov2;
  logic [9:0] od0, od2;
  logic [7:0] od1;
  logic [3:0] oc0, oc1, oc2;
  logic       oo0, oo1, oo2;

  localparam int MAXT [3] = '{8, 8, 1};
  localparam int MAXV [3] = '{1023, 255, 1023};

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    int inst;
    int d;
    int c;
    int o;
  } exp_t;

  exp_t sb[$];

  int o_valid [3];
  int o_ready [3];
  int o_data  [3];
  int o_count [3];
  int o_ovf   [3];

  psum_accumulator #(.IN_W(6), .ACC_W(10), .MAX_TERMS(8), .CNT_W(4)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir0), .in_data(in_data),
    .in_last(in_last), .out_valid(ov0), .out_ready(out_ready), .out_data(od0),
    .out_count(oc0), .out_ovf(oo0)
  );

  psum_accumulator #(.IN_W(6), .ACC_W(8), .MAX_TERMS(8), .CNT_W(4)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir1), .in_data(in_data),
    .in_last(in_last), .out_valid(ov1), .out_ready(out_ready), .out_data(od1),
    .out_count(oc1), .out_ovf(oo1)
  );

  psum_accumulator #(.IN_W(6), .ACC_W(10), .MAX_TERMS(1), .CNT_W(4)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir2), .in_data(in_data),
    .in_last(in_last), .out_valid(ov2), .out_ready(out_ready), .out_data(od2),
    .out_count(oc2), .out_ovf(oo2)
  );

  always #5 clk = ~clk;

  // Collect the three DUTs' outputs into indexable arrays
  always_comb begin
    o_valid[0] = int'(ov0); o_valid[1] = int'(ov1); o_valid[2] = int'(ov2);
    o_ready[0] = int'(ir0); o_ready[1] = int'(ir1); o_ready[2] = int'(ir2);
    o_data[0]  = int'(od0); o_data[1]  = int'(od1); o_data[2]  = int'(od2);
    o_count[0] = int'(oc0); o_count[1] = int'(oc1); o_count[2] = int'(oc2);
    o_ovf[0]   = int'(oo0); o_ovf[1]   = int'(oo1); o_ovf[2]   = int'(oo2);
  end

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Apply one cycle of inputs; returns 1 time unit after the consuming edge
  task automatic step(input bit v, input int d, input bit l, input bit r);
    in_valid  = v;
    in_data   = 6'(d);
    in_last   = l;
    out_ready = r;
    @(posedge clk);
    #1;
  endtask

  // Reference model: group totals from plain integer sums
  int  pv   [3];
  int  gsum [3];
  int  gcnt [3];
  bit  mr;
  exp_t e;

  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (!rst_n) begin
        check("reset_out_valid", o_valid[i], 0);
        check("reset_out_data", o_data[i], 0);
        check("reset_out_count", o_count[i], 0);
        check("reset_out_ovf", o_ovf[i], 0);
        pv[i]   = 0;
        gsum[i] = 0;
        gcnt[i] = 0;
      end else begin
        mr = (pv[i] == 0) || out_ready;
        check($sformatf("in_ready[%0d]", i), o_ready[i], int'(mr));
        check($sformatf("out_valid[%0d]", i), o_valid[i], pv[i]);
        if (pv[i] != 0 && out_ready) pv[i] = 0;
        if (in_valid && mr) begin
          gsum[i] += int'(in_data);
          gcnt[i]++;
          if (in_last || gcnt[i] == MAXT[i]) begin
            e.inst = i;
            e.d    = (gsum[i] > MAXV[i]) ? MAXV[i] : gsum[i];
            e.o    = (gsum[i] > MAXV[i]) ? 1 : 0;
            e.c    = gcnt[i];
            sb.push_back(e);
            pv[i]   = 1;
            gsum[i] = 0;
            gcnt[i] = 0;
          end
        end
      end
    end
    if (!rst_n) sb.delete();
  end

  // Monitor: compare each consumed result against the scoreboard; check hold stability
  int hold   [3];
  int h_data [3];
  int h_cnt  [3];
  int h_ovf  [3];
  int idx;

  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (rst_n && hold[i] != 0) begin
        check($sformatf("hold_data[%0d]", i), o_data[i], h_data[i]);
        check($sformatf("hold_count[%0d]", i), o_count[i], h_cnt[i]);
        check($sformatf("hold_ovf[%0d]", i), o_ovf[i], h_ovf[i]);
      end
      if (rst_n && o_valid[i] != 0 && out_ready) begin
        idx = -1;
        for (int k = 0; k < sb.size(); k++) begin
          if (idx < 0 && sb[k].inst == i) idx = k;
        end
        check($sformatf("result_expected[%0d]", i), int'(idx >= 0), 1);
        if (idx >= 0) begin
          check($sformatf("out_data[%0d]", i), o_data[i], sb[idx].d);
          check($sformatf("out_count[%0d]", i), o_count[i], sb[idx].c);
          check($sformatf("out_ovf[%0d]", i), o_ovf[i], sb[idx].o);
          sb.delete(idx);
        end
      end
      hold[i]   = (rst_n && o_valid[i] != 0 && !out_ready) ? 1 : 0;
      h_data[i] = o_data[i];
      h_cnt[i]  = o_count[i];
      h_ovf[i]  = o_ovf[i];
    end
  end

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    in_last   = 1'b0;
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("reset_in_ready", int'(ir0), 1);
    check("reset_valid0", int'(ov0), 0);
    rst_n = 1'b1;

    // Basic group
    step(1, 10, 0, 1);
    step(1, 20, 0, 1);
    step(1, 30, 1, 1);
    check("basic_data", int'(od0), 60);
    check("basic_count", int'(oc0), 3);
    check("basic_ovf", int'(oo0), 0);
    step(0, 0, 0, 1);

    // Forced close at MAX_TERMS
    repeat (8) step(1, 60, 0, 1);
    check("forced_data", int'(od0), 480);
    check("forced_count", int'(oc0), 8);
    check("forced_sat8_data", int'(od1), 255);
    step(1, 5, 1, 1);
    check("after_forced_data", int'(od0), 5);
    check("after_forced_count", int'(oc0), 1);
    step(0, 0, 0, 1);

    // Saturation on the 8-bit instance
    repeat (4) step(1, 60, 0, 1);
    step(1, 60, 1, 1);
    check("sat_data", int'(od1), 255);
    check("sat_ovf", int'(oo1), 1);
    check("sat_count", int'(oc1), 5);
    check("nosat_data", int'(od0), 300);
    step(1, 7, 1, 1);
    check("post_sat_data", int'(od1), 7);
    check("post_sat_ovf", int'(oo1), 0);
    step(0, 0, 0, 1);

    // Backpressure
    step(1, 3, 0, 1);
    step(1, 4, 1, 1);
    for (int c = 0; c < 5; c++) begin
      step(1, 9, 1, 0);
      check("bp_in_ready", int'(ir0), 0);
      check("bp_data", int'(od0), 7);
      check("bp_valid", int'(ov0), 1);
    end
    step(1, 9, 1, 1);
    check("bp_release_data", int'(od0), 9);
    check("bp_release_count", int'(oc0), 1);
    step(0, 0, 0, 1);

    // Zero-bubble reload with MAX_TERMS=1
    step(1, 1, 0, 1);
    check("zb_data1", int'(od2), 1);
    check("zb_count1", int'(oc2), 1);
    step(1, 2, 0, 1);
    check("zb_data2", int'(od2), 2);
    check("zb_valid2", int'(ov2), 1);
    step(1, 3, 0, 1);
    check("zb_data3", int'(od2), 3);
    step(1, 0, 1, 1);
    check("zb_group_data", int'(od0), 6);

    // Asynchronous reset mid-group and mid-result
    step(1, 40, 0, 1);
    step(1, 50, 0, 1);
    #2;
    rst_n    = 1'b0;
    in_valid = 1'b0;
    #1;
    check("async_rst_data0", int'(od0), 0);
    check("async_rst_data2", int'(od2), 0);
    check("async_rst_valid2", int'(ov2), 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    step(1, 6, 1, 1);
    check("post_rst_data", int'(od0), 6);
    check("post_rst_count", int'(oc0), 1);
    step(0, 0, 0, 1);

    // Randomized traffic
    for (int n = 0; n < 3000; n++) begin
      step(($urandom_range(0, 9) < 7), int'($urandom_range(0, 63)),
           ($urandom_range(0, 3) == 0), ($urandom_range(0, 9) < 7));
    end

    repeat (4) step(0, 0, 0, 1);
    check("scoreboard_drained", sb.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
